// File: rtl/track_pkg.sv
// Shared definitions for the track actuator: FSM states, drive codes and widths.
package track_pkg;

  localparam int NSW   = 3;
  localparam int DRV_W = 2;
  localparam int TMR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HALT   = 2'd1,
    ST_PULSE  = 2'd2,
    ST_SETTLE = 2'd3
  } track_state_e;

  localparam logic [DRV_W-1:0] DRV_STOP = 2'b00;
  localparam logic [DRV_W-1:0] DRV_FWD  = 2'b01;
  localparam logic [DRV_W-1:0] DRV_REV  = 2'b10;
  localparam logic [DRV_W-1:0] DRV_ILL  = 2'b11;

endpackage

// File: rtl/track_timer.sv
// Loadable down-counter; done is high during the last cycle of a loaded interval.
module track_timer
  import track_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // A load of N gives exactly N cycles before the owning state exits.
  assign done = (cnt_q == TMR_W'(1));

endmodule

// File: rtl/track_actuator.sv
// Switch-throw sequencer with motor interlock: halt trains, pulse solenoids, settle, resume.
module track_actuator
  import track_pkg::*;
#(
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NSW:1]     sw,
  input  logic [DRV_W-1:0] da,
  input  logic [DRV_W-1:0] db,
  output logic [NSW:1]     sol_set,
  output logic [NSW:1]     sol_clr,
  output logic [NSW:1]     sw_pos,
  output logic [DRV_W-1:0] ma,
  output logic [DRV_W-1:0] mb,
  output logic             busy,
  output logic             fault
);

  function automatic logic [DRV_W-1:0] legal_drv(input logic [DRV_W-1:0] d);
    return (d == DRV_ILL) ? DRV_STOP : d;
  endfunction

  track_state_e     state_q, state_d;
  logic [NSW:1]     target_q, target_d;
  logic [NSW:1]     sol_set_d, sol_clr_d, sw_pos_d;
  logic [DRV_W-1:0] ma_d, mb_d;
  logic             busy_d, fault_d;
  logic             tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val;

  track_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      sol_set  <= '0;
      sol_clr  <= '0;
      sw_pos   <= '0;
      ma       <= DRV_STOP;
      mb       <= DRV_STOP;
      busy     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sol_set  <= sol_set_d;
      sol_clr  <= sol_clr_d;
      sw_pos   <= sw_pos_d;
      ma       <= ma_d;
      mb       <= mb_d;
      busy     <= busy_d;
      fault    <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    sol_set_d = sol_set;
    sol_clr_d = sol_clr;
    sw_pos_d  = sw_pos;
    ma_d      = DRV_STOP;
    mb_d      = DRV_STOP;
    busy_d    = busy;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    // Illegal codes are watched in every state, even when motors are interlocked.
    fault_d   = fault | (da == DRV_ILL) | (db == DRV_ILL);

    case (state_q)
      ST_IDLE: begin
        if (sw != sw_pos) begin
          state_d  = ST_HALT;
          target_d = sw;
          busy_d   = 1'b1;
        end else begin
          ma_d   = legal_drv(da);
          mb_d   = legal_drv(db);
          busy_d = 1'b0;
        end
      end
      ST_HALT: begin
        state_d   = ST_PULSE;
        sol_set_d = target_q & ~sw_pos;
        sol_clr_d = ~target_q & sw_pos;
        tmr_load  = 1'b1;
        tmr_val   = TMR_W'(PULSE_CYCLES);
      end
      ST_PULSE: begin
        if (tmr_done) begin
          state_d   = ST_SETTLE;
          sol_set_d = '0;
          sol_clr_d = '0;
          sw_pos_d  = target_q;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(SETTLE_CYCLES);
        end
      end
      ST_SETTLE: begin
        if (tmr_done) begin
          // A request that arrived mid-sequence chains straight into a new halt.
          if (sw != sw_pos) begin
            state_d  = ST_HALT;
            target_d = sw;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            ma_d    = legal_drv(da);
            mb_d    = legal_drv(db);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_track_actuator.sv
// Scoreboard bench for track_actuator: per-cycle expected outputs queued and checked after each edge.
module tb_track_actuator;

  localparam int P = 4;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:1] sw = 3'b000;
  logic [1:0] da = 2'b00;
  logic [1:0] db = 2'b00;
  logic [3:1] sol_set, sol_clr, sw_pos;
  logic [1:0] ma, mb;
  logic       busy, fault;

  logic [14:0] obs;
  logic [14:0] exp_v;
  logic [14:0] sb[$];
  int n_checks = 0;
  int n_fail = 0;

  assign obs = {sol_set, sol_clr, sw_pos, ma, mb, busy, fault};

  track_actuator #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .da(da), .db(db),
    .sol_set(sol_set), .sol_clr(sol_clr), .sw_pos(sw_pos),
    .ma(ma), .mb(mb), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  // Idle/steady expectation: no solenoids, not busy.
  function automatic logic [14:0] pk(input logic [2:0] pos, input logic [1:0] a,
                                     input logic [1:0] b, input logic f);
    return {3'b000, 3'b000, pos, a, b, 1'b0, f};
  endfunction

  // Expected outputs k cycles after a switch request from 'from' to 'to':
  // k=1 halt, k=2..1+P pulse, then settle, then idle with motors restored.
  function automatic logic [14:0] seq_exp(input int k, input logic [2:0] from,
                                          input logic [2:0] to, input logic [1:0] a,
                                          input logic [1:0] b);
    logic [2:0] ss, sc, pos;
    logic [1:0] ea, eb;
    logic       bz;
    ss = 3'b000; sc = 3'b000; pos = from; ea = 2'b00; eb = 2'b00; bz = 1'b1;
    if (k >= 2 && k <= 1 + P) begin
      ss = to & ~from;
      sc = ~to & from;
    end
    if (k >= 2 + P) pos = to;
    if (k >= 2 + P + S) begin
      bz = 1'b0; ea = a; eb = b;
    end
    return {ss, sc, pos, ea, eb, bz, 1'b0};
  endfunction

  task automatic test_reset();
    sw = 3'b111; da = 2'b01; db = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_async got=%b exp=%b", obs, 15'd0);
    end
    for (int i = 0; i < 2; i++) sb.push_back(15'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 2 + P + S; k++) sb.push_back(seq_exp(k, 3'b000, 3'b111, 2'b01, 2'b00));
    for (int k = 1; k <= 2 + P + S; k++) begin
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_release k=%0d got=%b exp=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_steady();
    logic [1:0] pa[3] = '{2'b01, 2'b10, 2'b00};
    logic [1:0] pb[3] = '{2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sw = 3'b111; da = pa[i]; db = pb[i];
      sb.push_back(pk(3'b111, pa[i], pb[i], 1'b0));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL steady i=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_throw();
    logic [2:0] fr[2] = '{3'b111, 3'b000};
    logic [2:0] tg[2] = '{3'b000, 3'b101};
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      sw = tg[t]; da = 2'b01; db = 2'b00;
      for (int k = 1; k <= 2 + P + S; k++) sb.push_back(seq_exp(k, fr[t], tg[t], 2'b01, 2'b00));
      for (int k = 1; k <= 2 + P + S; k++) begin
        @(posedge clk); #1;
        exp_v = sb.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL throw t=%0d k=%0d got=%b exp=%b", t, k, obs, exp_v);
        end
      end
    end
  endtask

  task automatic test_mixed();
    @(negedge clk);
    sw = 3'b011; da = 2'b01; db = 2'b10;
    for (int k = 1; k <= 2 + P + S; k++) sb.push_back(seq_exp(k, 3'b101, 3'b011, 2'b01, 2'b10));
    for (int k = 1; k <= 2 + P + S; k++) begin
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL mixed k=%0d got=%b exp=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_change_mid_pulse();
    @(negedge clk);
    sw = 3'b000; da = 2'b01; db = 2'b00;
    for (int k = 1; k <= 2 + P + S; k++) sb.push_back(seq_exp(k, 3'b011, 3'b000, 2'b01, 2'b00));
    for (int k = 1; k <= 2 + P + S; k++) begin
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL chg_prep k=%0d got=%b exp=%b", k, obs, exp_v);
      end
    end
    @(negedge clk);
    sw = 3'b001;
    for (int k = 1; k <= 1 + P + S; k++) sb.push_back(seq_exp(k, 3'b000, 3'b001, 2'b01, 2'b00));
    for (int k = 1; k <= 2 + P + S; k++) sb.push_back(seq_exp(k, 3'b001, 3'b011, 2'b01, 2'b00));
    for (int k = 1; k <= 3 + 2 * (P + S); k++) begin
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL chg_mid k=%0d got=%b exp=%b", k, obs, exp_v);
      end
      if (k == 3) begin
        @(negedge clk);
        sw = 3'b011;
      end
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    sw = 3'b100; da = 2'b01; db = 2'b00;
    for (int k = 1; k <= 2; k++) sb.push_back(seq_exp(k, 3'b011, 3'b100, 2'b01, 2'b00));
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL abort_pulse k=%0d got=%b exp=%b", k, obs, exp_v);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 15'd0) begin
      n_fail++;
      $display("FAIL abort_async got=%b exp=%b", obs, 15'd0);
    end
    @(negedge clk);
    sw = 3'b000; rst_n = 1'b1;
    sb.push_back(pk(3'b000, 2'b01, 2'b00, 1'b0));
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL abort_idle got=%b exp=%b", obs, exp_v);
    end
  endtask

  task automatic test_fault();
    logic [1:0] pb[3] = '{2'b11, 2'b00, 2'b10};
    logic [1:0] eb[3] = '{2'b00, 2'b00, 2'b10};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sw = 3'b000; da = 2'b01; db = pb[i];
      sb.push_back(pk(3'b000, 2'b01, eb[i], 1'b1));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL fault i=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_throw();
    test_mixed();
    test_change_mid_pulse();
    test_abort();
    test_fault();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
